user_play_datapath: RTL
=======================

// Module: user_play_datapath
// PURPOSE
//  Datapath for the PLAY_USER/CHECK phases of the memory game. Driven by the game controller's r2/e2/e4.
//  - Captures the player's KEY entries and compares each one with the sequence ROM.
//  - Runs the 0..9 s play timer (HEX2).
//  - Returns end_user, end_time and match to the controller, which reads them in PLAY_USER and CHECK.
// PARAMETERS
//  TICK_DIV     50_000_000  clock cycles per 1 Hz timer tick (use a small value in simulation)
//  TIME_MAX     9           last timer value; the tick that would advance past it is the timeout
//  DEBOUNCE_CYC 1_000_000   cycles a KEY vector must be stable before it is accepted
// PORTS
//  clock      in   1  system clock, rising edge
//  reset      in   1  synchronous, active-high; clears everything
//  r2         in   1  round clear from controller (synchronous, same effect as reset on this block)
//  e2         in   1  user-play enable (controller in PLAY_USER)
//  e4         in   1  check enable (controller in CHECK)
//  key_n      in   4  raw KEY[3:0], active-low, asynchronous
//  round_len  in   5  entries expected this round, 1..16; 0 is treated as 1
//  seq_data   in   4  ROM line at seq_addr (combinational ROM)
//  seq_addr   out  4  index of the next expected entry (= user_cnt[3:0])
//  user_cnt   out  5  entries accepted so far, 0..16
//  time_cnt   out  4  seconds elapsed, 0..TIME_MAX, for HEX2
//  last_key   out  4  last accepted entry, for LEDR[3:0]
//  end_user   out  1  level: all round_len entries accepted
//  end_time   out  1  level: timer expired before completion
//  match      out  1  e4 & end_user & ~mismatch (combinational from registers)
// BEHAVIOUR
//  - Reset/r2: all registers 0, state IDLE, outputs 0. reset and r2 take priority over all else.
//  - key_n path:
//    - Two-flop synchroniser, then invert to pressed[3:0].
//    - Debounce counter restarts on any change of pressed. After DEBOUNCE_CYC stable cycles, the value
//      becomes keys_db. The synchroniser and debouncer run regardless of e2.
//  - FSM:
//    - IDLE: when e2=1, go to WAIT. Prescaler and time_cnt start from 0.
//    - WAIT: when keys_db != 0, go to HOLD; hold_acc <= keys_db.
//    - HOLD: hold_acc |= keys_db each cycle; multi-key chords are allowed.
//      - On keys_db == 0 (release), accept the entry:
//        - last_key <= hold_acc.
//        - mismatch <= mismatch | (hold_acc != seq_data).
//        - user_cnt++.
//      - If the new user_cnt == max(round_len,1): go to DONE and assert end_user; else go to WAIT.
//    - DONE: hold all values. Ignore keys and timer. Leave only via r2/reset.
//    - TIMEOUT: end_time=1. Hold all values. Leave only via r2/reset.
//  - Timer (runs in WAIT/HOLD only while e2=1):
//    - Prescaler counts 0..TICK_DIV-1; tick = wrap.
//    - On tick: if time_cnt < TIME_MAX then time_cnt++; else go to TIMEOUT.
//    - time_cnt never exceeds TIME_MAX; no wrap to 0.
//  - Simultaneous final release and timeout tick in the same cycle: timeout wins.
//    - State goes to TIMEOUT, end_user stays 0.
//    - The entry is not counted.
//  - e2 drop in WAIT/HOLD: freeze prescaler, timer, counters and hold_acc. Resume when e2 returns.
//  - Latency: end_user rises on the first edge after the release is seen on keys_db.
//    Both end flags are registered outputs.
//  - Entries beyond 16 cannot occur: DONE is reached at 16.
//  - seq_addr = user_cnt[3:0] at all times.
// TESTING
//  - round_len=3; ROM={1,2,4}; press/release KEY0, KEY1, KEY2 -> end_user=1 after 3rd release,
//    user_cnt=3, match=1 when e4=1.
//  - Same setup, 2nd entry KEY3 (4'h8) -> end_user=1 after 3rd release, match=0 under e4.
//  - TICK_DIV=4, no keys, e2=1 -> time_cnt 0..9 at 4-cycle spacing; end_time=1 on the next tick;
//    time_cnt stays 9; end_user=0.
//  - 3-cycle key glitch with DEBOUNCE_CYC=8 -> no entry accepted, user_cnt=0.
//  - Chord KEY0+KEY2 held, then released -> last_key=4'h5; compared against seq_data=4'h5 -> no mismatch.
//  - Final release coincident with timeout tick -> end_time=1, end_user=0.
//    Then r2 pulse -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/user_play_datapath.sv
// Player-entry datapath for the memory game: debounced KEY capture,
// per-entry comparison with the sequence ROM, and the play timer.
module user_play_datapath #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int TIME_MAX     = 9,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       r2,
   input  logic       e2,
   input  logic       e4,
   input  logic [3:0] key_n,
   input  logic [4:0] round_len,
   input  logic [3:0] seq_data,
   output logic [3:0] seq_addr,
   output logic [4:0] user_cnt,
   output logic [3:0] time_cnt,
   output logic [3:0] last_key,
   output logic       end_user,
   output logic       end_time,
   output logic       match
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [3:0]    T_MAX   = 4'(TIME_MAX);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_HOLD = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_TOUT = 3'd4;

   logic          clr;
   logic [3:0]    s1_q, s2_q;
   logic [3:0]    cand_q, cand_d;
   logic [DW-1:0] dbc_q, dbc_d;
   logic [3:0]    kdb_q, kdb_d;
   logic [2:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [3:0]    time_q, time_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [3:0]    acc_q, acc_d;
   logic [3:0]    last_q, last_d;
   logic          mis_q, mis_d;
   logic          eu_q, eu_d;
   logic          et_q, et_d;
   logic          run, tick;
   logic [4:0]    rl_eff, cnt_inc;

   assign clr = reset | r2;

   // Synchroniser stores the pressed polarity so a cleared register means "no key".
   always_comb begin
      cand_d = cand_q;
      dbc_d  = dbc_q;
      kdb_d  = kdb_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         dbc_d  = '0;
      end else if (dbc_q != DB_MAX) begin
         dbc_d = dbc_q + 1'b1;
      end else begin
         kdb_d = cand_q;
      end
   end

   assign run     = e2 && (state_q == S_WAIT || state_q == S_HOLD);
   assign tick    = run && (pre_q == PRE_MAX);
   assign rl_eff  = (round_len == 5'd0) ? 5'd1 : round_len;
   assign cnt_inc = cnt_q + 5'd1;

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      time_d  = time_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      last_d  = last_q;
      mis_d   = mis_q;
      eu_d    = eu_q;
      et_d    = et_q;
      if (run)
         pre_d = tick ? '0 : pre_q + 1'b1;
      unique case (state_q)
         S_IDLE: if (e2) state_d = S_WAIT;
         S_WAIT, S_HOLD: begin
            // Timeout outranks a release arriving on the same edge.
            if (tick && time_q == T_MAX) begin
               state_d = S_TOUT;
               et_d    = 1'b1;
            end else if (run) begin
               if (tick)
                  time_d = time_q + 4'd1;
               if (state_q == S_WAIT) begin
                  if (kdb_q != 4'd0) begin
                     state_d = S_HOLD;
                     acc_d   = kdb_q;
                  end
               end else if (kdb_q == 4'd0) begin
                  last_d = acc_q;
                  mis_d  = mis_q | (acc_q != seq_data);
                  cnt_d  = cnt_inc;
                  if (cnt_inc == rl_eff || cnt_inc == 5'd16) begin
                     state_d = S_DONE;
                     eu_d    = 1'b1;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else begin
                  acc_d = acc_q | kdb_q;
               end
            end
         end
         S_DONE, S_TOUT: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         s1_q    <= '0;
         s2_q    <= '0;
         cand_q  <= '0;
         dbc_q   <= '0;
         kdb_q   <= '0;
         state_q <= S_IDLE;
         pre_q   <= '0;
         time_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         last_q  <= '0;
         mis_q   <= 1'b0;
         eu_q    <= 1'b0;
         et_q    <= 1'b0;
      end else begin
         s1_q    <= ~key_n;
         s2_q    <= s1_q;
         cand_q  <= cand_d;
         dbc_q   <= dbc_d;
         kdb_q   <= kdb_d;
         state_q <= state_d;
         pre_q   <= pre_d;
         time_q  <= time_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         last_q  <= last_d;
         mis_q   <= mis_d;
         eu_q    <= eu_d;
         et_q    <= et_d;
      end
   end

   assign seq_addr = cnt_q[3:0];
   assign user_cnt = cnt_q;
   assign time_cnt = time_q;
   assign last_key = last_q;
   assign end_user = eu_q;
   assign end_time = et_q;
   assign match    = e4 & eu_q & ~mis_q;

endmodule
